// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register and load writeback formatter
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               exception/ERET flush, inserts a WB bubble
//   mem_stall           MEM output not a valid instruction this cycle
//   wb_stall            freeze WB register contents
//   mem_we/waddr/wdata  MEM destination and ALU/move result
//   mem_load_op         0 NONE,1 LB,2 LBU,3 LH,4 LHU,5 LW,6 LWL,7 LWR
//   mem_addr_lo         effective address bits [1:0]
//   mem_rt_data         old rt value for LWL/LWR merge
//   dram_rdata          synchronous data-RAM read word, valid in WB cycle
//   wb_we/waddr/wdata   register-file write port
module mem_wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        mem_stall,
    input  logic        wb_stall,
    input  logic        mem_we,
    input  logic [4:0]  mem_waddr,
    input  logic [31:0] mem_wdata,
    input  logic [2:0]  mem_load_op,
    input  logic [1:0]  mem_addr_lo,
    input  logic [31:0] mem_rt_data,
    input  logic [31:0] dram_rdata,
    output logic        wb_we,
    output logic [4:0]  wb_waddr,
    output logic [31:0] wb_wdata
);
    logic        r_we, hold_vld;
    logic [4:0]  r_waddr;
    logic [31:0] r_wdata, r_rt, hold_buf;
    logic [2:0]  r_load_op;
    logic [1:0]  r_addr_lo;
    logic [31:0] ld, lwl, lwr, fmt;
    logic [7:0]  b;
    logic [15:0] h;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we      <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_load_op <= '0;
            r_addr_lo <= '0;
            r_rt      <= '0;
            hold_buf  <= '0;
            hold_vld  <= 1'b0;
        end else if (flush) begin
            r_we      <= 1'b0;
            r_load_op <= '0;
            hold_vld  <= 1'b0;
        end else if (wb_stall) begin
            // the RAM word is only valid in the first stalled cycle; keep it
            if (r_load_op != 3'd0 && !hold_vld) begin
                hold_buf <= dram_rdata;
                hold_vld <= 1'b1;
            end
        end else if (mem_stall) begin
            r_we      <= 1'b0;
            r_load_op <= '0;
            hold_vld  <= 1'b0;
        end else begin
            r_we      <= mem_we;
            r_waddr   <= mem_waddr;
            r_wdata   <= mem_wdata;
            r_load_op <= mem_load_op;
            r_addr_lo <= mem_addr_lo;
            r_rt      <= mem_rt_data;
            hold_vld  <= 1'b0;
        end
    end

    assign ld  = hold_vld ? hold_buf : dram_rdata;
    assign b   = ld[{r_addr_lo, 3'b000} +: 8];
    assign h   = r_addr_lo[1] ? ld[31:16] : ld[15:0];
    assign lwl = r_addr_lo == 2'd0 ? {ld[7:0], r_rt[23:0]} :
                 r_addr_lo == 2'd1 ? {ld[15:0], r_rt[15:0]} :
                 r_addr_lo == 2'd2 ? {ld[23:0], r_rt[7:0]} : ld;
    assign lwr = r_addr_lo == 2'd0 ? ld :
                 r_addr_lo == 2'd1 ? {r_rt[31:24], ld[31:8]} :
                 r_addr_lo == 2'd2 ? {r_rt[31:16], ld[31:16]} : {r_rt[31:8], ld[31:24]};
    assign fmt = r_load_op == 3'd1 ? {{24{b[7]}}, b} :
                 r_load_op == 3'd2 ? {24'd0, b} :
                 r_load_op == 3'd3 ? {{16{h[15]}}, h} :
                 r_load_op == 3'd4 ? {16'd0, h} :
                 r_load_op == 3'd5 ? ld :
                 r_load_op == 3'd6 ? lwl :
                 r_load_op == 3'd7 ? lwr : r_wdata;

    assign wb_we    = r_we && r_waddr != 5'd0;
    assign wb_waddr = r_waddr;
    assign wb_wdata = wb_we ? fmt : 32'd0;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed and randomized checks of mem_wb_stage against a reference model
module tb_mem_wb_stage;
    logic        clk = 0, rst = 0, flush = 0, mem_stall = 0, wb_stall = 0, mem_we = 0;
    logic [4:0]  mem_waddr = 0;
    logic [31:0] mem_wdata = 0, mem_rt_data = 0, dram_rdata = 0;
    logic [2:0]  mem_load_op = 0;
    logic [1:0]  mem_addr_lo = 0;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    int n_chk = 0, n_err = 0;

    logic        m_we, m_held;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata, m_rt, m_word;
    logic [2:0]  m_op;
    logic [1:0]  m_lo;

    mem_wb_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .mem_stall(mem_stall), .wb_stall(wb_stall),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_load_op(mem_load_op), .mem_addr_lo(mem_addr_lo), .mem_rt_data(mem_rt_data),
        .dram_rdata(dram_rdata), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fmt(input logic [2:0] op, input logic [1:0] lo,
                                        input logic [31:0] ld, input logic [31:0] rt,
                                        input logic [31:0] wd);
        int s, s2;
        logic [31:0] byt, half;
        s    = 8 * int'(lo);
        s2   = 24 - s;
        byt  = (ld >> s) & 32'hFF;
        half = (ld >> (16 * int'(lo[1]))) & 32'hFFFF;
        case (op)
            3'd1: return byt | (byt >= 32'd128 ? 32'hFFFF_FF00 : 32'd0);
            3'd2: return byt;
            3'd3: return half | (half >= 32'h8000 ? 32'hFFFF_0000 : 32'd0);
            3'd4: return half;
            3'd5: return ld;
            3'd6: return (ld << s2) | (rt & ((32'd1 << s2) - 32'd1));
            3'd7: return (ld >> s) | (rt & ~(32'hFFFF_FFFF >> s));
            default: return wd;
        endcase
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_we = 0; m_waddr = 0; m_wdata = 0; m_op = 0; m_lo = 0; m_rt = 0; m_word = 0; m_held = 0;
        end else if (flush || (mem_stall && !wb_stall)) begin
            m_we = 0; m_op = 0; m_held = 0;
        end else if (wb_stall) begin
            if (m_op != 0 && !m_held) begin
                m_word = dram_rdata;
                m_held = 1;
            end
        end else begin
            m_we = mem_we; m_waddr = mem_waddr; m_wdata = mem_wdata;
            m_op = mem_load_op; m_lo = mem_addr_lo; m_rt = mem_rt_data; m_held = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk_model(input string tag);
        logic e_we;
        e_we = m_we && m_waddr != 0;
        chk({tag, ".we"}, 32'(wb_we), 32'(e_we));
        chk({tag, ".waddr"}, 32'(wb_waddr), 32'(m_waddr));
        chk({tag, ".wdata"}, wb_wdata,
            e_we ? fmt(m_op, m_lo, m_held ? m_word : dram_rdata, m_rt, m_wdata) : 32'd0);
    endtask

    task automatic issue(input logic we, input logic [4:0] a, input logic [31:0] d,
                         input logic [2:0] op, input logic [1:0] lo, input logic [31:0] rt);
        mem_we = we; mem_waddr = a; mem_wdata = d; mem_load_op = op; mem_addr_lo = lo; mem_rt_data = rt;
    endtask

    initial begin
        rst = 1;
        tick();
        rst = 0;
        chk("reset.we", 32'(wb_we), 0);
        chk("reset.waddr", 32'(wb_waddr), 0);
        chk("reset.wdata", wb_wdata, 0);

        issue(1, 5, 32'h1234_5678, 0, 0, 0); tick();
        chk("alu.we", 32'(wb_we), 1);
        chk("alu.waddr", 32'(wb_waddr), 5);
        chk("alu.wdata", wb_wdata, 32'h1234_5678);

        dram_rdata = 32'h80FF_7F01;
        issue(1, 7, 0, 1, 3, 0); tick(); chk("lb3", wb_wdata, 32'hFFFF_FF80);
        issue(1, 7, 0, 2, 3, 0); tick(); chk("lbu3", wb_wdata, 32'h0000_0080);
        issue(1, 7, 0, 3, 2, 0); tick(); chk("lh2", wb_wdata, 32'hFFFF_80FF);
        issue(1, 7, 0, 4, 0, 0); tick(); chk("lhu0", wb_wdata, 32'h0000_7F01);

        dram_rdata = 32'h4433_2211;
        issue(1, 8, 0, 6, 1, 32'hAABB_CCDD); tick(); chk("lwl1", wb_wdata, 32'h2211_CCDD);
        issue(1, 8, 0, 7, 2, 32'hAABB_CCDD); tick(); chk("lwr2", wb_wdata, 32'hAABB_4433);

        dram_rdata = 32'hCAFE_0001;
        issue(1, 10, 0, 5, 0, 0); tick(); chk("lw", wb_wdata, 32'hCAFE_0001);
        issue(1, 9, 32'h55, 0, 0, 0);
        wb_stall = 1; mem_stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            dram_rdata = 32'hDEAD_BEEF;
            #1;
            chk("hold.wdata", wb_wdata, 32'hCAFE_0001);
            chk("hold.waddr", 32'(wb_waddr), 10);
        end
        wb_stall = 0; mem_stall = 0;
        tick();
        chk("release.waddr", 32'(wb_waddr), 9);
        chk("release.wdata", wb_wdata, 32'h55);

        issue(1, 3, 32'h77, 0, 0, 0); mem_stall = 1; tick();
        chk("mstall.we", 32'(wb_we), 0);
        chk("mstall.wdata", wb_wdata, 0);
        mem_stall = 0; tick(); chk("after.we", 32'(wb_we), 1);
        flush = 1; wb_stall = 1; tick();
        chk("flush.we", 32'(wb_we), 0);
        flush = 0; wb_stall = 0;

        issue(1, 11, 0, 5, 0, 0); dram_rdata = 32'h0BAD_F00D; tick();
        wb_stall = 1; tick();
        dram_rdata = 32'h1111_2222; #1;
        chk("rsthold.wdata", wb_wdata, 32'h0BAD_F00D);
        rst = 1; tick(); rst = 0;
        chk("rstmid.we", 32'(wb_we), 0);
        chk("rstmid.waddr", 32'(wb_waddr), 0);
        chk("rstmid.wdata", wb_wdata, 0);
        wb_stall = 0;

        issue(1, 0, 32'hFFFF_FFFF, 0, 0, 0); tick();
        chk("zero.we", 32'(wb_we), 0);
        chk("zero.wdata", wb_wdata, 0);
        issue(1, 0, 0, 5, 0, 0); tick();
        chk("zeroload.we", 32'(wb_we), 0);

        for (int i = 0; i < 2000; i++) begin
            rst       = $urandom_range(63) == 0;
            flush     = $urandom_range(15) == 0;
            wb_stall  = $urandom_range(3) == 0;
            mem_stall = $urandom_range(4) == 0;
            issue($urandom_range(3) != 0, 5'($urandom_range(31)), $urandom,
                  3'($urandom_range(7)), 2'($urandom_range(3)), $urandom);
            tick();
            dram_rdata = $urandom;
            #1;
            chk_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
